// File: rtl/mode_arbiter_if.sv
// mode_arbiter_if: button inputs, per-mode display buses and muxed board outputs of the mode arbiter.
interface mode_arbiter_if #(parameter int NUM_MODES = 4);
  logic                   btn_mode;
  logic                   btn_up, btn_down, btn_left, btn_right, btn_confirm;
  logic [16*NUM_MODES-1:0] mode_led;
  logic [20*NUM_MODES-1:0] mode_seg;
  logic [4*NUM_MODES-1:0]  mode_dp;
  logic [NUM_MODES-1:0]    mode_active;
  logic                   mode_btn_up, mode_btn_down, mode_btn_left, mode_btn_right, mode_btn_confirm;
  logic [15:0]            led;
  logic [19:0]            seg_data;
  logic [3:0]             dp_data;
  logic [1:0]             cur_mode;
  modport slave (
    input  btn_mode, btn_up, btn_down, btn_left, btn_right, btn_confirm, mode_led, mode_seg, mode_dp,
    output mode_active, mode_btn_up, mode_btn_down, mode_btn_left, mode_btn_right, mode_btn_confirm,
           led, seg_data, dp_data, cur_mode
  );
  modport master (
    output btn_mode, btn_up, btn_down, btn_left, btn_right, btn_confirm, mode_led, mode_seg, mode_dp,
    input  mode_active, mode_btn_up, mode_btn_down, mode_btn_left, mode_btn_right, mode_btn_confirm,
           led, seg_data, dp_data, cur_mode
  );
endinterface

// File: rtl/mode_arbiter.sv
// mode_arbiter: cycles game modes on btn_mode, showing a "-0n-" banner with all modes inactive between them.
module mode_arbiter #(
  parameter int NUM_MODES     = 4,
  parameter int BANNER_CYCLES = 100_000_000
) (
  input logic            clk,
  input logic            reset,
  mode_arbiter_if.slave  bus
);
  localparam int CW = BANNER_CYCLES > 1 ? $clog2(BANNER_CYCLES) : 1;
  localparam logic [0:0] S_BANNER = 1'b0;
  localparam logic [0:0] S_RUN    = 1'b1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BANNER_CYCLES - 1);
  logic [0:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [1:0]           r_mode;
  logic                 r_prev;
  logic [NUM_MODES-1:0] r_active;
  logic [15:0]          r_led;
  logic [19:0]          r_seg;
  logic [3:0]           r_dp;
  logic                 w_edge, w_any_btn, w_run_nx;
  logic [1:0]           w_mode_inc, w_mode_nx;
  logic [0:0]           w_state_nx;
  logic [CW-1:0]        w_cnt_nx;
  always_comb begin
    w_edge     = bus.btn_mode & ~r_prev;
    w_any_btn  = |{bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_confirm};
    w_mode_inc = (r_mode == 2'(NUM_MODES - 1)) ? 2'd0 : r_mode + 2'd1;
    w_mode_nx  = w_edge ? w_mode_inc : r_mode;
    // a held game button at expiry parks the counter at max until release
    w_state_nx = w_edge ? S_BANNER :
                 (r_state == S_BANNER && r_cnt == CNT_MAX && !w_any_btn) ? S_RUN : r_state;
    w_cnt_nx   = w_edge ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    w_run_nx   = (w_state_nx == S_RUN);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= S_BANNER;
      r_cnt    <= '0;
      r_mode   <= 2'd0;
      r_prev   <= 1'b0;
      r_active <= '0;
      r_led    <= '0;
      r_seg    <= {5'd10, 5'd0, 5'd1, 5'd10};
      r_dp     <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_mode   <= w_mode_nx;
      r_prev   <= bus.btn_mode;
      r_active <= w_run_nx ? NUM_MODES'(1) << w_mode_nx : '0;
      r_led    <= w_run_nx ? bus.mode_led[16*w_mode_nx +: 16] : 16'd0;
      r_seg    <= w_run_nx ? bus.mode_seg[20*w_mode_nx +: 20] : {5'd10, 5'd0, 5'(w_mode_nx) + 5'd1, 5'd10};
      r_dp     <= w_run_nx ? bus.mode_dp[4*w_mode_nx +: 4] : 4'd0;
    end
  assign bus.mode_active      = r_active;
  assign bus.led              = r_led;
  assign bus.seg_data         = r_seg;
  assign bus.dp_data          = r_dp;
  assign bus.cur_mode         = r_mode;
  assign bus.mode_btn_up      = bus.btn_up      & (r_state == S_RUN) & ~bus.btn_mode;
  assign bus.mode_btn_down    = bus.btn_down    & (r_state == S_RUN) & ~bus.btn_mode;
  assign bus.mode_btn_left    = bus.btn_left    & (r_state == S_RUN) & ~bus.btn_mode;
  assign bus.mode_btn_right   = bus.btn_right   & (r_state == S_RUN) & ~bus.btn_mode;
  assign bus.mode_btn_confirm = bus.btn_confirm & (r_state == S_RUN) & ~bus.btn_mode;
endmodule
